// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, CLKS_PER_BIT clocks per bit, mid-bit sampling after a
// 2-flop synchronizer, with a valid/ready output register that reports dropped bytes.
module uart_rx #(
   parameter int CLKS_PER_BIT = 4
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   input  logic       rx_ready,
   output logic       busy,
   output logic       frame_err,
   output logic       overrun
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_HALF = CW'(CLKS_PER_BIT/2 - 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t        state, state_nx;
   logic [CW-1:0] cnt, cnt_nx;
   logic [2:0]    bit_idx, bit_idx_nx;
   logic [7:0]    shreg, shreg_nx;
   logic          armed, armed_nx;
   logic          sync1, rx_s;
   logic          done_ok, done_bad;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1 <= 1'b1;
         rx_s  <= 1'b1;
      end else begin
         sync1 <= rx;
         rx_s  <= sync1;
      end
   end

   // armed: the line has been seen idle (1) since reset or the last framing error,
   // so a low level in IDLE is a genuine start edge rather than a held-low line.
   always_comb begin
      state_nx   = state;
      cnt_nx     = cnt;
      bit_idx_nx = bit_idx;
      shreg_nx   = shreg;
      armed_nx   = armed;
      done_ok    = 1'b0;
      done_bad   = 1'b0;
      case (state)
         IDLE: begin
            cnt_nx = '0;
            if (rx_s)
               armed_nx = 1'b1;
            else if (armed)
               state_nx = START;
         end
         START: begin
            if (cnt == CNT_HALF) begin
               cnt_nx     = '0;
               bit_idx_nx = 3'd0;
               state_nx   = rx_s ? IDLE : DATA;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         DATA: begin
            if (cnt == CNT_LAST) begin
               cnt_nx            = '0;
               shreg_nx[bit_idx] = rx_s;
               if (bit_idx == 3'd7)
                  state_nx = STOP;
               else
                  bit_idx_nx = bit_idx + 3'd1;
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         STOP: begin
            if (cnt == CNT_LAST) begin
               cnt_nx   = '0;
               state_nx = IDLE;
               if (rx_s) begin
                  done_ok = 1'b1;
               end else begin
                  done_bad = 1'b1;
                  armed_nx = 1'b0;
               end
            end else begin
               cnt_nx = cnt + 1'b1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= IDLE;
         cnt       <= '0;
         bit_idx   <= 3'd0;
         shreg     <= 8'h00;
         armed     <= 1'b0;
         busy      <= 1'b0;
         frame_err <= 1'b0;
         overrun   <= 1'b0;
         rx_data   <= 8'h00;
         rx_valid  <= 1'b0;
      end else begin
         state     <= state_nx;
         cnt       <= cnt_nx;
         bit_idx   <= bit_idx_nx;
         shreg     <= shreg_nx;
         armed     <= armed_nx;
         busy      <= (state_nx != IDLE);
         frame_err <= done_bad;
         overrun   <= done_ok && rx_valid && !rx_ready;
         // A byte finishing in the same cycle as a read replaces the old one.
         if (done_ok && (!rx_valid || rx_ready)) begin
            rx_data  <= shreg;
            rx_valid <= 1'b1;
         end else if (rx_valid && rx_ready) begin
            rx_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_uart_rx.sv
// Randomized + directed bench for uart_rx; a cycle-indexed schedule of frame
// completions and busy windows drives a per-cycle output model.
module tb_uart_rx;
   localparam int CPB  = 4;
   localparam int LAT  = 2 + CPB/2 + 9*CPB;  // first low edge -> completion edge
   localparam int NCYC = 8192;

   logic       clk = 1'b0, rst = 1'b0, rx = 1'b1, rx_ready = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid, busy, frame_err, overrun;

   uart_rx #(.CLKS_PER_BIT(CPB)) dut (
      .clk(clk), .rst(rst), .rx(rx), .rx_data(rx_data), .rx_valid(rx_valid),
      .rx_ready(rx_ready), .busy(busy), .frame_err(frame_err), .overrun(overrun)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   bit         exp_busy[NCYC];
   bit         ev_on[NCYC];
   bit         ev_ok[NCYC];
   logic [7:0] ev_byte[NCYC];

   int n_vec = 0, n_err = 0;
   int ready_mode = 1;  // 0 random, 1 held high, 2 held low
   int fe_cnt = 0, ov_cnt = 0, rise_cyc = -1;
   logic [7:0] rise_q[$];

   always @(posedge clk) begin
      #2;
      rx_ready = (ready_mode == 0) ? ($urandom_range(0, 1) == 1) : (ready_mode == 1);
   end

   // Output model
   logic       m_valid = 1'b0;
   logic [7:0] m_data = 8'h00;
   bit         prev_ready = 1'b1;
   logic       dut_valid_d = 1'b0;

   always @(negedge clk) begin
      logic e_fe, e_ov, e_busy;
      bit   clr;
      e_fe = 1'b0; e_ov = 1'b0; e_busy = 1'b0;
      if (rst) begin
         m_valid = 1'b0;
         m_data  = 8'h00;
      end else if (cyc < NCYC) begin
         clr = m_valid && prev_ready;
         if (ev_on[cyc]) begin
            if (!ev_ok[cyc]) begin
               e_fe = 1'b1;
               if (clr) m_valid = 1'b0;
            end else if (!m_valid || prev_ready) begin
               m_data  = ev_byte[cyc];
               m_valid = 1'b1;
            end else begin
               e_ov = 1'b1;
            end
         end else if (clr) begin
            m_valid = 1'b0;
         end
         e_busy = exp_busy[cyc];
      end
      n_vec++;
      if ({rx_valid, rx_data, busy, frame_err, overrun} !== {m_valid, m_data, e_busy, e_fe, e_ov}) begin
         n_err++;
         $display("FAIL cycle %0d outputs: got valid=%b data=%h busy=%b fe=%b ov=%b, want valid=%b data=%h busy=%b fe=%b ov=%b",
                  cyc, rx_valid, rx_data, busy, frame_err, overrun, m_valid, m_data, e_busy, e_fe, e_ov);
      end
      if (frame_err === 1'b1) fe_cnt++;
      if (overrun === 1'b1) ov_cnt++;
      if (rx_valid === 1'b1 && dut_valid_d !== 1'b1) begin
         rise_cyc = cyc;
         rise_q.push_back(rx_data);
      end
      dut_valid_d = rx_valid;
      prev_ready  = rx_ready;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #2;
   endtask

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h want %0h", nm, got, exp);
      end
   endtask

   task automatic schedule(input int k, input logic [7:0] b, input bit ok);
      for (int c = k + 2; c < k + LAT; c++) exp_busy[c] = 1'b1;
      ev_on[k+LAT]   = 1'b1;
      ev_ok[k+LAT]   = ok;
      ev_byte[k+LAT] = b;
   endtask

   task automatic send(input logic [7:0] b, input bit stop_ok, input int gap, output int k);
      k = cyc + 1;
      schedule(k, b, stop_ok);
      rx = 1'b0; tick(CPB);
      for (int i = 0; i < 8; i++) begin rx = b[i]; tick(CPB); end
      rx = stop_ok; tick(CPB);
      rx = 1'b1;
      if (gap > 0) tick(gap);
   endtask

   task automatic glitch(input int len);
      int k;
      k = cyc + 1;
      exp_busy[k+2] = 1'b1;
      exp_busy[k+3] = 1'b1;
      rx = 1'b0; tick(len);
      rx = 1'b1; tick(4);
   endtask

   initial begin
      int k, qs, fe0, ov0, r, gap;
      bit ok;
      #1 rst = 1'b1;
      tick(3);
      chk("reset rx_valid", {31'd0, rx_valid}, 32'd0);
      chk("reset rx_data", {24'd0, rx_data}, 32'h00);
      chk("reset busy", {31'd0, busy}, 32'd0);
      rst = 1'b0;
      tick(3);

      // A5, latency to rx_valid
      send(8'hA5, 1'b1, 6, k);
      chk("A5 rise edge", rise_cyc, k + 40);
      chk("A5 data", {24'd0, rise_q[$]}, 32'hA5);

      // back-to-back
      qs = rise_q.size();
      send(8'h00, 1'b1, 0, k);
      send(8'hFF, 1'b1, 0, k);
      send(8'h3C, 1'b1, 6, k);
      chk("b2b count", rise_q.size() - qs, 3);
      chk("b2b byte0", {24'd0, rise_q[qs]}, 32'h00);
      chk("b2b byte1", {24'd0, rise_q[qs+1]}, 32'hFF);
      chk("b2b byte2", {24'd0, rise_q[qs+2]}, 32'h3C);

      // one-cycle glitch
      qs = rise_q.size(); fe0 = fe_cnt;
      glitch(1);
      tick(4);
      chk("glitch no valid", rise_q.size(), qs);
      chk("glitch no fe", fe_cnt, fe0);

      // bad stop then good byte
      send(8'h55, 1'b0, 3, k);
      chk("bad stop fe", fe_cnt, fe0 + 1);
      chk("bad stop no valid", rise_q.size(), qs);
      send(8'h81, 1'b1, 6, k);
      chk("after fe data", {24'd0, rise_q[$]}, 32'h81);

      // overrun with consumer stalled
      ready_mode = 2; tick(2);
      ov0 = ov_cnt;
      send(8'h12, 1'b1, 0, k);
      send(8'h34, 1'b1, 6, k);
      chk("overrun held data", {24'd0, rx_data}, 32'h12);
      chk("overrun held valid", {31'd0, rx_valid}, 32'd1);
      chk("overrun pulses", ov_cnt, ov0 + 1);
      ready_mode = 1; tick(3);
      chk("overrun drained", {31'd0, rx_valid}, 32'd0);

      // reset during data bit 3 of F0
      qs = rise_q.size();
      k = cyc + 1;
      schedule(k, 8'hF0, 1'b1);
      rx = 1'b0; tick(CPB);
      for (int i = 0; i < 3; i++) begin rx = 1'b0; tick(CPB); end
      rx = 1'b0; tick(2);
      rst = 1'b1; rx = 1'b1;
      for (int c = cyc; c <= k + LAT; c++) begin
         exp_busy[c] = 1'b0; ev_on[c] = 1'b0;
      end
      tick(3);
      rst = 1'b0;
      tick(4);
      chk("abort no valid", rise_q.size(), qs);
      send(8'h0F, 1'b1, 6, k);
      chk("after abort data", {24'd0, rise_q[$]}, 32'h0F);

      // randomized frames, glitches, bad stops, random ready
      ready_mode = 0;
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 99);
         if (r < 10) begin
            glitch($urandom_range(1, 2));
         end else begin
            ok  = (r >= 25);
            gap = ok ? $urandom_range(0, 3) : $urandom_range(1, 3);
            send(8'($urandom_range(0, 255)), ok, gap, k);
         end
      end
      tick(10);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter: CLKS_PER_BIT, default 4, clk cycles per serial bit; it shall be an even value of at least 4.
REQ-002 Port: clk  input  1  single clock; all state shall update on the rising edge.
REQ-003 Port: rst  input  1  reset, asynchronous and active-high.
REQ-004 Port: rx  input  1  serial line; idle level is 1.
REQ-005 Port: rx_data  output  8  last received byte.
REQ-006 Port: rx_valid  output  1  rx_data holds an unread byte.
REQ-007 Port: rx_ready  input  1  consumer accepts rx_data.
REQ-008 Port: busy  output  1  a frame is in progress.
REQ-009 Port: frame_err  output  1  one-cycle pulse on a bad stop bit.
REQ-010 Port: overrun  output  1  one-cycle pulse when a completed byte is dropped.

Function
REQ-011 Frame format: 1 start bit (0), 8 data bits LSB first, 1 stop bit (1); each bit is CLKS_PER_BIT cycles; no parity.
REQ-012 rx shall pass through a 2-flop synchronizer before any use; rx_s denotes the synchronizer output.
REQ-013 The FSM shall have the states IDLE, START, DATA and STOP; a bit counter of 3 bits; a cycle counter cnt sized for CLKS_PER_BIT-1; and an 8-bit shift register.
REQ-014 IDLE: when rx_s==0, go to START with cnt=0; otherwise remain in IDLE.
REQ-015 START: increment cnt each cycle until cnt==CLKS_PER_BIT/2-1; on that cycle, if rx_s==1 (glitch) return to IDLE with no output, otherwise go to DATA with cnt=0 and bit index=0.
REQ-016 DATA: increment cnt each cycle until cnt==CLKS_PER_BIT-1; on that cycle, shift rx_s into bit[index] and set cnt=0; after index 7, go to STOP; otherwise increment index.
REQ-017 STOP: increment cnt each cycle until cnt==CLKS_PER_BIT-1; on that cycle, go to IDLE and evaluate rx_s per REQ-018 and REQ-019.
REQ-018 Stop bit rx_s==1: the byte is complete; deliver it per REQ-020 and REQ-021.
REQ-019 Stop bit rx_s==0: pulse frame_err for one cycle, discard the byte, and leave rx_data and rx_valid unchanged; IDLE then waits for rx_s==1 before accepting a new start.
REQ-020 Handshake: rx_valid shall stay high with rx_data stable until a cycle with rx_valid && rx_ready, after which rx_valid clears on the next edge.
REQ-021 Completion with rx_valid==0, or with rx_valid && rx_ready in the same cycle: load rx_data and set rx_valid=1; no overrun.
REQ-022 Completion with rx_valid==1 && rx_ready==0: keep the old rx_data, drop the new byte, and pulse overrun for one cycle.
REQ-023 busy shall be 1 exactly when the state is not IDLE, as a registered output.
REQ-024 Back-to-back frames (stop bit followed immediately by a start bit) shall be received without loss.
REQ-025 frame_err and overrun shall never assert in the same cycle.

Reset
REQ-026 While rst==1: state=IDLE, counters=0, both synchronizer flops=1, rx_data=8'h00, rx_valid=0, busy=0, frame_err=0, overrun=0.
REQ-027 Asserting rst mid-frame shall abort the frame immediately with no output.
REQ-028 After rst is released, a frame shall be accepted only after rx_s has been observed at 1 in IDLE.

Verification
REQ-029 The bench shall cover these directed scenarios (CLKS_PER_BIT=4, rx_ready held 1 unless stated):
- Byte 8'hA5 -> rx_data=8'hA5, rx_valid rises on the 41st clk edge after rx falls, busy=1 through the frame.
- Bytes 8'h00, 8'hFF, 8'h3C sent back-to-back -> three rx_valid pulses carrying 8'h00, 8'hFF, 8'h3C in order.
- rx low for 1 cycle only -> returns to IDLE, no rx_valid, no frame_err.
- Byte 8'h55 with the stop bit forced to 0 -> frame_err pulses for 1 cycle, rx_valid stays 0, then 8'h81 with a good stop bit -> 8'h81 delivered.
- rx_ready=0, bytes 8'h12 then 8'h34 -> rx_data remains 8'h12 and overrun pulses once; raising rx_ready then clears rx_valid.
- rst asserted during data bit 3 of 8'hF0, then a clean 8'h0F -> no output for the aborted frame, 8'h0F delivered.
